// File: rtl/pi1_arbiter_pkg.sv
// Shared PI1 definitions for the arbiter slice: op encodings and the
// arbiter FSM state type. Op codes live only here and are imported by
// every file that needs them.
package pi1_arbiter_pkg;

  // PI1 operation encodings.
  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  // Arbiter FSM states; also exported on the debug state port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Downstream address width for a given data width: the byte-lane bits
  // are carried by the select lines instead of the address.
  function automatic int pi1_addr_width(input int archbitsz);
    return archbitsz - $clog2(archbitsz / 8);
  endfunction

endpackage

// File: rtl/pi1_rrsel.sv
// Round-robin selector: purely combinational. Scans the request vector
// starting one past the last grant and wrapping, so the most recent
// owner has the lowest priority on the next arbitration.
module pi1_rrsel
  import pi1_arbiter_pkg::*;
#(
  parameter int MASTERCOUNT = 2
) (
  input  logic [MASTERCOUNT-1:0]         req,
  input  logic [$clog2(MASTERCOUNT)-1:0] last_grant,
  output logic [$clog2(MASTERCOUNT)-1:0] winner,
  output logic                           valid
);

  localparam int GW = $clog2(MASTERCOUNT);

  // First requester found in rotated order wins; later hits are ignored.
  always_comb begin
    logic [GW-1:0] cand;
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= MASTERCOUNT; k++) begin
      cand = GW'((int'(last_grant) + k) % MASTERCOUNT);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/pi1_arbiter.sv
// PI1 arbiter: shares one downstream PI1 port between MASTERCOUNT masters
// with round-robin fairness.
//
// Handshake: a master presents a non-NOOP op and holds it (with its
// address/data/sel) until it sees its own m_rdy_o bit high for one cycle.
// Downstream, s_op_o != NOOP together with s_rdy_i = 1 in GRANT is the
// acceptance; the first WAIT cycle with s_rdy_i = 1 is the response, which
// is forwarded to the owner as m_rdy_o[grant] = 1 with m_data_o = s_data_i.
//
// Optional watchdog: define PI1_ARBITER_WDT_EN to add a TIMEOUT-cycle
// limit on GRANT/WAIT and the sticky wdt_o output.
module pi1_arbiter
  import pi1_arbiter_pkg::*;
#(
  parameter int ARCHBITSZ   = 32,
  parameter int MASTERCOUNT = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [2*MASTERCOUNT-1:0]                      m_op_i,
  input  logic [MASTERCOUNT*pi1_addr_width(ARCHBITSZ)-1:0] m_addr_i,
  input  logic [MASTERCOUNT*ARCHBITSZ-1:0]              m_data_i,
  input  logic [MASTERCOUNT*(ARCHBITSZ/8)-1:0]          m_sel_i,
  output logic [ARCHBITSZ-1:0]                          m_data_o,
  output logic [MASTERCOUNT-1:0]                        m_rdy_o,
  output logic [1:0]                                    s_op_o,
  output logic [pi1_addr_width(ARCHBITSZ)-1:0]          s_addr_o,
  output logic [ARCHBITSZ-1:0]                          s_data_o,
  output logic [ARCHBITSZ/8-1:0]                        s_sel_o,
  input  logic [ARCHBITSZ-1:0]                          s_data_i,
  input  logic                                          s_rdy_i,
  output logic [$clog2(MASTERCOUNT)-1:0]                grant_o,
  output logic                                          busy_o,
`ifdef PI1_ARBITER_WDT_EN
  output logic                                          wdt_o,
`endif
  output arb_state_e                                    state_o
);

  localparam int AW = pi1_addr_width(ARCHBITSZ);
  localparam int SW = ARCHBITSZ / 8;
  localparam int GW = $clog2(MASTERCOUNT);

  arb_state_e state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;

  logic [1:0]           op_arr   [MASTERCOUNT];
  logic [AW-1:0]        addr_arr [MASTERCOUNT];
  logic [ARCHBITSZ-1:0] data_arr [MASTERCOUNT];
  logic [SW-1:0]        sel_arr  [MASTERCOUNT];
  logic [MASTERCOUNT-1:0] req_vec;

  logic [GW-1:0] rr_winner;
  logic          rr_valid;
  logic          busy;
  logic          wdt_hit;

  // Split the flat per-master buses into indexable fields.
  for (genvar g = 0; g < MASTERCOUNT; g++) begin : g_unpack
    assign op_arr[g]   = m_op_i[2*g +: 2];
    assign addr_arr[g] = m_addr_i[AW*g +: AW];
    assign data_arr[g] = m_data_i[ARCHBITSZ*g +: ARCHBITSZ];
    assign sel_arr[g]  = m_sel_i[SW*g +: SW];
    assign req_vec[g]  = (op_arr[g] != PINOOP);
  end

  pi1_rrsel #(
    .MASTERCOUNT(MASTERCOUNT)
  ) u_rrsel (
    .req       (req_vec),
    .last_grant(last_q),
    .winner    (rr_winner),
    .valid     (rr_valid)
  );

  assign busy    = (state_q != ST_IDLE);
  assign busy_o  = busy;
  assign grant_o = grant_q;
  assign state_o = state_q;

`ifdef PI1_ARBITER_WDT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wdt_cnt_q;
  logic          wdt_q;

  // The owner has held the port for TIMEOUT cycles: abandon it.
  assign wdt_hit = busy && (wdt_cnt_q == CW'(TIMEOUT));

  // Watchdog counter restarts every time the FSM passes through IDLE, so
  // it reads 0 in the first GRANT cycle; the alarm flag is sticky.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wdt_cnt_q <= '0;
      wdt_q     <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        wdt_cnt_q <= '0;
      end else begin
        wdt_cnt_q <= wdt_cnt_q + CW'(1);
      end
      if (wdt_hit) begin
        wdt_q <= 1'b1;
      end
    end
  end

  assign wdt_o = wdt_q | (wdt_hit & rst_i);
`else
  assign wdt_hit = 1'b0;
`endif

  // State, current grant and last-grant registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(MASTERCOUNT - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic plus the downstream mirror and upstream response.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    s_op_o   = PINOOP;
    s_addr_o = addr_arr[grant_q];
    s_data_o = data_arr[grant_q];
    s_sel_o  = sel_arr[grant_q];
    m_rdy_o  = '0;
    m_data_o = '0;

    case (state_q)
      ST_IDLE: begin
        // Arbitration only happens here, so the grant is stable while busy.
        if (rr_valid) begin
          grant_d = rr_winner;
          last_d  = rr_winner;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (wdt_hit) begin
          m_rdy_o[grant_q] = 1'b1;
          state_d          = ST_IDLE;
        end else if (op_arr[grant_q] == PINOOP) begin
          // Owner withdrew before acceptance: nothing goes downstream.
          state_d = ST_IDLE;
        end else begin
          s_op_o = op_arr[grant_q];
          if (s_rdy_i) begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (wdt_hit) begin
          m_rdy_o[grant_q] = 1'b1;
          state_d          = ST_IDLE;
        end else if (s_rdy_i) begin
          m_rdy_o[grant_q] = 1'b1;
          m_data_o         = s_data_i;
          state_d          = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A transaction cut short by reset must not complete or issue.
    if (!rst_i) begin
      s_op_o   = PINOOP;
      m_rdy_o  = '0;
      m_data_o = '0;
    end
  end

endmodule
